lcd_bus_sched: RTL
==================

// Module: lcd_bus_sched
// PURPOSE
//  Owns the 8-bit HD44780-style character LCD bus and shares it between two writers.
//  Runs the power-on init sequence, then round-robin arbitrates byte writes (rs, data).
//  Generates E setup/pulse/hold timing and a per-command busy wait; never reads the LCD (rw=0).
//  Sits between the display-content producers (text/time formatter, debug/SRAM dumper) and the LCD pins.
// PARAMETERS
//  E_SETUP    1      cycles rs/data are stable with E low before E rises (>=1)
//  E_HIGH     3      cycles E is held high (>=1)
//  CMD_WAIT   40     cycles E low after a normal write before the next transfer (>=1)
//  LONG_WAIT  1600   cycles E low after clear/home (rs=0, data 8'h01..8'h03) (>=CMD_WAIT)
//  INIT_WAIT  20000  power-on idle cycles before the first init command (>=1)
//  CNT_W      16     width of the shared delay counter; must hold every wait value above
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous reset, active low
//  req0_valid  in   1  requester 0 has a byte to write
//  req0_rs     in   1  requester 0 register select (0 = command, 1 = data)
//  req0_data   in   8  requester 0 byte
//  req0_ready  out  1  requester 0 byte accepted this cycle (valid & ready)
//  req1_valid  in   1  requester 1 has a byte to write
//  req1_rs     in   1  requester 1 register select
//  req1_data   in   8  requester 1 byte
//  req1_ready  out  1  requester 1 byte accepted this cycle
//  init_done   out  1  high once the init sequence has completed; stays high until reset
//  lcd_e       out  1  LCD enable strobe (registered)
//  lcd_rs      out  1  LCD register select (registered)
//  lcd_rw      out  1  tied 0
//  lcd_data    out  8  LCD data bus (registered)
// BEHAVIOUR
//  Reset (async, rst=0): state=PWR_WAIT, counter=0, init index=0, rr pointer=0; lcd_e=0, lcd_rs=0,
//   lcd_data=8'h00, init_done=0, req*_ready=0. Reset mid-transfer aborts it; init re-runs in full.
//  States: PWR_WAIT -> INIT_LOAD -> SETUP -> PULSE -> HOLD -> (INIT_LOAD | IDLE); IDLE -> SETUP.
//  PWR_WAIT: E low for INIT_WAIT cycles, then INIT_LOAD.
//  INIT_LOAD: drives rs=0, data = init table [38,06,0C,01][index]; index++; -> SETUP. After the
//   HOLD of entry 3 (01, long wait): init_done=1 -> IDLE.
//  IDLE: ready combinational = (state==IDLE) & init_done & grant. Grant: if only one valid, that one;
//   both valid -> requester named by rr pointer; pointer then flips to the non-granted requester.
//   Pointer changes only on an accepted transfer. At most one ready high per cycle.
//  Accept at cycle t: lcd_rs/lcd_data take the granted rs/data at edge ending t, -> SETUP.
//  SETUP E_SETUP cycles (E=0), PULSE E_HIGH cycles (E=1), HOLD wait cycles (E=0); rs/data held
//   constant from accept until the next accept/INIT_LOAD. wait = LONG_WAIT if rs=0 and
//   data[7:2]==0 and data[1:0]!=0, else CMD_WAIT.
//  Throughput: next ready no earlier than t+1+E_SETUP+E_HIGH+wait; back-to-back valids accepted at
//   exactly that cycle. Requests during PWR_WAIT/INIT are held off (ready=0), never dropped.
//  Requester must hold valid/rs/data stable until ready; dropping valid before ready is legal.
//  One shared down-counter loaded on each state entry; state advances when it reaches 1.
// STRUCTURE
//  lcd_pkg: state enum, init command constants (FUNCTION_SET 8'h38, ENTRY_MODE 8'h06,
//   DISP_ON 8'h0C, CLEAR 8'h01), is_long_cmd() function.
//  Sub-module lcd_rr_arb2: 2-way round-robin arbiter (valid[1:0], accept -> grant one-hot, pointer).
// TESTING (E_SETUP=1, E_HIGH=2, CMD_WAIT=4, LONG_WAIT=10, INIT_WAIT=5)
//  1 Power-on: no requests -> E pulses for 38,06,0C,01 in order, rs=0, each E high 2 cycles; gaps
//    4,4,4 then 10 cycles; init_done rises after last HOLD; req0_valid held during init -> ready=0.
//  2 Single writer: req0 (rs=1, 8'h41) at IDLE -> ready same cycle; lcd_data=41, rs=1 next cycle;
//    E high cycles t+2..t+3; next ready on still-valid req0 exactly at t+8.
//  3 Contention: both valid continuously, req0=8'h30.., req1=8'h60.. -> grants alternate 0,1,0,1;
//    first grant to req0 after reset; never both ready in one cycle.
//  4 Long command: req1 rs=0 8'h01 -> 10-cycle hold before next ready; rs=0 8'h04 and rs=1 8'h01
//    -> 4-cycle hold.
//  5 Reset mid-PULSE: rst low while E=1 -> E, rs, data, init_done to 0 immediately; full init reruns.
//  6 Valid withdrawn before grant: req1 drops valid during HOLD -> no transfer; pointer unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character LCD bus scheduler:
// FSM state codes, power-on init commands and command classification.
package lcd_pkg;

    localparam logic [2:0] ST_PWR_WAIT  = 3'd0;
    localparam logic [2:0] ST_INIT_LOAD = 3'd1;
    localparam logic [2:0] ST_SETUP     = 3'd2;
    localparam logic [2:0] ST_PULSE     = 3'd3;
    localparam logic [2:0] ST_HOLD      = 3'd4;
    localparam logic [2:0] ST_IDLE      = 3'd5;

    localparam logic [7:0] FUNCTION_SET = 8'h38;
    localparam logic [7:0] ENTRY_MODE   = 8'h06;
    localparam logic [7:0] DISP_ON      = 8'h0C;
    localparam logic [7:0] CLEAR        = 8'h01;

    localparam int INIT_LEN = 4;

    // Clear/home style commands need the long busy wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = FUNCTION_SET;
            2'd1:    c = ENTRY_MODE;
            2'd2:    c = DISP_ON;
            default: c = CLEAR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_bus_sched_arb.sv
// Two-way round-robin arbiter; pointer names the favoured
// requester on contention and moves only on an accepted transfer.
module lcd_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       ptr
);

    // One-hot grant: a lone requester wins, contention goes to ptr.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer moves to the requester that lost (or was absent).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= 1'b0;
        else if (accept)
            ptr <= grant[0];
    end

endmodule

// File: rtl/lcd_bus_sched.sv
// HD44780-style LCD bus owner: power-on init, then round-robin
// byte writes from two requesters with E timing and busy waits.
module lcd_bus_sched
    import lcd_pkg::*;
#(
    parameter int E_SETUP   = 1,
    parameter int E_HIGH    = 3,
    parameter int CMD_WAIT  = 40,
    parameter int LONG_WAIT = 1600,
    parameter int INIT_WAIT = 20000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [1:0]       grant;
    logic             ptr;
    logic             idle_ok;
    logic             accept;
    logic             pwr_last;

    assign lcd_rw     = 1'b0;
    assign idle_ok    = (state == ST_IDLE) && init_done;
    assign req0_ready = idle_ok && grant[0];
    assign req1_ready = idle_ok && grant[1];
    assign accept     = req0_ready || req1_ready;

    // Counter is 0 only on the first power-on cycle; a 1-cycle wait ends there.
    assign pwr_last = (cnt == CNT_W'(1)) ||
                      ((cnt == '0) && (INIT_WAIT == 1));

    lcd_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant),
        .ptr    (ptr)
    );

    // Sequencer: shared down-counter, state advances when it reaches 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_PWR_WAIT;
            cnt       <= '0;
            idx       <= '0;
            init_done <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            case (state)
                ST_PWR_WAIT: begin
                    if (pwr_last)
                        state <= ST_INIT_LOAD;
                    else if (cnt == '0)
                        cnt <= CNT_W'(INIT_WAIT - 1);
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_INIT_LOAD: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_cmd(idx[1:0]);
                    idx      <= idx + 1'b1;
                    cnt      <= CNT_W'(E_SETUP);
                    state    <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (cnt == CNT_W'(1)) begin
                        lcd_e <= 1'b1;
                        cnt   <= CNT_W'(E_HIGH);
                        state <= ST_PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == CNT_W'(1)) begin
                        lcd_e <= 1'b0;
                        cnt   <= is_long_cmd(lcd_rs, lcd_data) ?
                                 CNT_W'(LONG_WAIT) : CNT_W'(CMD_WAIT);
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == CNT_W'(1)) begin
                        if (init_done) begin
                            state <= ST_IDLE;
                        end else if (idx == 3'(INIT_LEN)) begin
                            init_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_INIT_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        lcd_rs   <= grant[1] ? req1_rs : req0_rs;
                        lcd_data <= grant[1] ? req1_data : req0_data;
                        cnt      <= CNT_W'(E_SETUP);
                        state    <= ST_SETUP;
                    end
                end
                default: state <= ST_PWR_WAIT;
            endcase
        end
    end

endmodule
